// File: rtl/bip_pkg.sv
// Shared definitions for the processor core: fetch sequencer state encoding
// and the default PC / cycle-counter widths.
package bip_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } pc_state_t;

    localparam int PC_LENGTH     = 11;
    localparam int CYCLE_COUNT_W = 32;

endpackage : bip_pkg

// File: rtl/cycle_counter.sv
// Saturating run-time counter: counts enabled cycles, synchronous clear has
// priority over counting, and the value sticks at all-ones instead of wrapping.
module cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Clear wins over count; saturate at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule : cycle_counter

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch/execute sequencer.
// Optional feature: define PC_CYCLE_COUNT_EN to build the saturating run-time
// counter behind cycle_count; without it cycle_count is tied to zero.
//
// Control inputs are level-sampled, not handshaked: start is only looked at in
// IDLE, clear only in HALTED, halt only in EXEC. There is no valid/ready pair;
// a held level is simply acted upon in the state that samples it.
// state_dbg exposes the FSM state register for checkers.
module pc_fetch_ctrl
    import bip_pkg::*;
#(
    parameter int LENGTH  = PC_LENGTH,
    parameter int COUNT_W = CYCLE_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    input  logic               halt,
    input  logic [LENGTH-1:0]  new_pc,
    output logic [LENGTH-1:0]  pc,
    output logic               pc_inc,
    output logic               exec_en,
    output logic               running,
    output logic               done,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [1:0]         state_dbg
);

    pc_state_t         state_q, state_d;
    logic [LENGTH-1:0] pc_q, pc_d;

    // State and PC registers; reset returns to IDLE at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and next-PC decode. new_pc is only consumed in EXEC; the
    // incrementer owns the arithmetic, so wrap-around needs no handling here.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    pc_d    = new_pc;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                if (clear) begin
                    pc_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // Output decode: everything from registered state except exec_en,
    // which must drop in the same EXEC cycle the decoder flags a HALT.
    always_comb begin
        pc_inc  = 1'b0;
        exec_en = 1'b0;
        running = 1'b0;
        done    = 1'b0;
        case (state_q)
            FETCH: begin
                running = 1'b1;
            end
            EXEC: begin
                running = 1'b1;
                pc_inc  = 1'b1;
                exec_en = ~halt;
            end
            HALTED: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc        = pc_q;
    assign state_dbg = state_q;

`ifdef PC_CYCLE_COUNT_EN
    logic cnt_en;
    logic cnt_clr;

    // Count every FETCH/EXEC cycle; restart only when a new run begins, so the
    // last run time survives HALTED and the return to IDLE.
    assign cnt_en  = (state_q == FETCH) || (state_q == EXEC);
    assign cnt_clr = (state_q == IDLE) && start;

    cycle_counter #(
        .W (COUNT_W)
    ) u_cycle_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (cycle_count)
    );
`else
    assign cycle_count = '0;
`endif

endmodule : pc_fetch_ctrl

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter register and fetch sequencer for the processor core. Holds the current PC, presents it to instruction memory and to the PC incrementer's `old_pc` input, drives the incrementer's `value` bit, and loads the incrementer's `new_pc` result back once per executed instruction. A four-state machine paces fetch and execute around the one-cycle instruction-memory read latency and stops the core on a halt instruction. An optional cycle counter reports the elapsed run time.

## Interface
- `LENGTH`, 11: PC / instruction-memory address width; must equal the incrementer's `LENGTH`.
- `COUNT_W`, 32: cycle-counter width.

- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin execution from address 0; level-sampled in IDLE only.
- `clear`  in  1: leave HALTED and return to IDLE; level-sampled in HALTED only.
- `halt`  in  1: decoder flag, current instruction is HALT; sampled in EXEC only.
- `new_pc`  in  LENGTH: incrementer result.
- `pc`  out  LENGTH: registered PC; drives instruction-memory address and incrementer `old_pc`.
- `pc_inc`  out  1: incrementer `value`; 1 in EXEC, else 0.
- `exec_en`  out  1: datapath write enable; 1 in EXEC when `halt`=0.
- `running`  out  1: state is FETCH or EXEC.
- `done`  out  1: state is HALTED.
- `cycle_count`  out  COUNT_W: elapsed run cycles (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: `pc`=0. `start`=1 -> FETCH. `clear` ignored.
- FETCH: memory samples `pc`; no register updates except the counter. -> EXEC unconditionally.
- EXEC: instruction word valid. `halt`=0 -> `pc` <= `new_pc`, -> FETCH. `halt`=1 -> `pc` held, `exec_en`=0, -> HALTED.
- HALTED: `pc` holds the HALT address. `clear`=1 -> IDLE, `pc` <= 0. `start` ignored.
- `start` and `clear` together: in IDLE `start` wins; in HALTED `clear` wins.
- Arithmetic is done by the incrementer. `new_pc` is loaded as-is. PC 2^LENGTH-1 wraps to 0 with no flag, and execution continues.
- `new_pc` is ignored outside EXEC.
- `rst_n` low at any time, including mid-instruction: state forced to IDLE, `pc`=0, counter=0, all outputs 0, asynchronously. The first `start` is accepted on the first edge after release.

## Timing
- Reset values: `pc`=0, `pc_inc`=0, `exec_en`=0, `running`=0, `done`=0, `cycle_count`=0.
- `start` high at edge n -> FETCH during cycle n+1.
- Each instruction takes two cycles, FETCH then EXEC. `pc` updates on the edge ending EXEC.
- `halt` seen in EXEC at edge m -> `done`=1 from cycle m+1.
- All outputs are decoded from registered state and PC. There is no combinational path from inputs to outputs, except `exec_en`, which depends on `halt`.

## Configuration
- Macro `PC_CYCLE_COUNT_EN`.
- Defined:
  - `cycle_count` increments on every cycle spent in FETCH or EXEC, and saturates at 2^COUNT_W-1.
  - Cleared on the IDLE->FETCH transition.
  - Held in HALTED and through `clear`.
- Undefined: the counter logic is absent and `cycle_count` is tied to 0.

## Structure
- Shared package `bip_pkg`:
  - state enum `pc_state_t` (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2, HALTED=2'd3);
  - `PC_LENGTH`=11;
  - `CYCLE_COUNT_W`=32.
- One natural sub-module: `cycle_counter` (enable, synchronous clear, saturation), instantiated only under `PC_CYCLE_COUNT_EN`.
- The incrementer stays external; this block connects to it.

## Test plan
- Reset release, `start` pulse, `halt`=0, and an ideal incrementer stub: `pc` sequence 0,1,2,3 with new values every 2 cycles; `running`=1.
- `halt`=1 on the 4th EXEC: `pc`=3 held, `done`=1 next cycle, `exec_en`=0 in that EXEC; with the macro, `cycle_count`=8.
- Start PC at 2047 (LENGTH=11) via a stub forcing `new_pc`: next `pc`=0 and execution continues.
- In HALTED, `start`=1 alone: no change. `start`=`clear`=1: IDLE, `pc`=0; `cycle_count` retains its value until the next `start`.
- `rst_n` asserted mid-EXEC with `pc`=5: all outputs 0 immediately, without a clock edge.
- Build without the macro and run scenario 2: `cycle_count` stays 0 throughout.
